// File: rtl/matmul_pkg.sv
// Shared types and constants for the parametrised matrix-multiply core.
package matmul_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LDN  = 4'd1,
    S_CHK  = 4'd2,
    S_RDA  = 4'd3,
    S_RDB  = 4'd4,
    S_MAC  = 4'd5,
    S_WRC  = 4'd6,
    S_NXT  = 4'd7,
    S_DONE = 4'd8
  } mm_state_t;

  localparam int N_ADDR = 0;
  localparam int A_OFF  = 1;

  // Accumulator width that cannot overflow for MAX_N signed products.
  function automatic int acc_w(input int data_w, input int max_n);
    return 2 * data_w + $clog2(max_n);
  endfunction

endpackage

// File: rtl/matmul_core_param_mac.sv
// Signed multiply-accumulate register plus result formatting.
// MATMUL_SAT_EN defined: results saturate to DATA_W; otherwise they wrap.
module matmul_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic [DATA_W-1:0]        sum_fmt
);
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign prod = PW'(a) * PW'(b);
  // sum is the value acc takes at the end of this MAC step; the FSM writes it out directly
  assign sum  = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    if (sum > SAT_MAX) begin
      sum_fmt = SAT_MAX[DATA_W-1:0];
    end else if (sum < SAT_MIN) begin
      sum_fmt = SAT_MIN[DATA_W-1:0];
    end else begin
      sum_fmt = sum[DATA_W-1:0];
    end
  end
`else
  assign sum_fmt = sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/matmul_core_param.sv
// Matrix-multiply core computing rows i = CORE_ID mod NUM_CORES of C = A x B
// over a req/ack memory port. Define MATMUL_SAT_EN to saturate written results.
module matmul_core_param
  import matmul_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int CORE_ID   = 0,
  parameter int NUM_CORES = 4,
  parameter int MAX_N     = 32
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              START,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              end_i,
  output logic              err
);
  localparam int ACC_W = acc_w(DATA_W, MAX_N);
  localparam int IW    = DATA_W + 1;

  mm_state_t         state;
  logic [DATA_W-1:0] n, a, b, c_fmt;
  logic [IW-1:0]     i, j, k, n_ext, i_nc, j_inc, k_inc;
  logic [ADDR_W-1:0] n_ad, a_row, a_row_nc, a_addr, b_addr, c_addr;
  logic              ack, start_ok, acc_clr, acc_en;

  assign ack      = mem_req & mem_ack;
  assign start_ok = START & ((state == S_IDLE) | (state == S_DONE));
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign acc_clr  = start_ok | (state == S_NXT);
  assign acc_en   = (state == S_MAC);

  // N is compared unsigned, so a negative N reads as oversized and flags err
  assign n_ext = {1'b0, n};
  assign i_nc  = i + IW'(NUM_CORES);
  assign j_inc = j + IW'(1);
  assign k_inc = k + IW'(1);

  // All address terms are truncated to ADDR_W so arithmetic wraps.
  assign n_ad     = ADDR_W'(n);
  assign a_row    = ADDR_W'(A_OFF) + ADDR_W'(i) * n_ad;
  assign a_row_nc = ADDR_W'(A_OFF) + ADDR_W'(i_nc) * n_ad;
  assign a_addr   = a_row + ADDR_W'(k);
  assign b_addr   = ADDR_W'(A_OFF) + n_ad * n_ad + ADDR_W'(k) * n_ad + ADDR_W'(j);
  assign c_addr   = ADDR_W'(A_OFF) + ADDR_W'(2) * n_ad * n_ad + ADDR_W'(i) * n_ad + ADDR_W'(j);

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (RESET),
    .clr     (acc_clr),
    .en      (acc_en),
    .a       (a),
    .b       (b),
    .sum_fmt (c_fmt)
  );

  // Request is raised on the edge that enters an access state, so a zero-wait access costs one cycle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      end_i     <= 1'b0;
      err       <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      n         <= '0;
      a         <= '0;
      b         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state    <= S_LDN;
            end_i    <= 1'b0;
            err      <= 1'b0;
            i        <= IW'(CORE_ID);
            j        <= '0;
            k        <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= ADDR_W'(N_ADDR);
          end
        end
        S_LDN: begin
          if (ack) begin
            n       <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_CHK;
          end
        end
        S_CHK: begin
          if (n_ext > IW'(MAX_N)) begin
            err   <= 1'b1;
            end_i <= 1'b1;
            state <= S_DONE;
          end else if ((n_ext == IW'(0)) || (i >= n_ext)) begin
            end_i <= 1'b1;
            state <= S_DONE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= a_addr;
            state    <= S_RDA;
          end
        end
        S_RDA: begin
          if (ack) begin
            a        <= mem_rdata;
            mem_addr <= b_addr;
            state    <= S_RDB;
          end
        end
        S_RDB: begin
          if (ack) begin
            b       <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          mem_req <= 1'b1;
          if (k_inc == n_ext) begin
            mem_we    <= 1'b1;
            mem_addr  <= c_addr;
            mem_wdata <= c_fmt;
            state     <= S_WRC;
          end else begin
            k        <= k_inc;
            mem_addr <= a_addr + ADDR_W'(1);
            state    <= S_RDA;
          end
        end
        S_WRC: begin
          if (ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_NXT;
          end
        end
        S_NXT: begin
          k <= '0;
          if (j_inc < n_ext) begin
            j        <= j_inc;
            mem_req  <= 1'b1;
            mem_addr <= a_row;
            state    <= S_RDA;
          end else begin
            j <= '0;
            i <= i_nc;
            if (i_nc >= n_ext) begin
              end_i <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= a_row_nc;
              state    <= S_RDA;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_core_param.sv
// Bench for matmul_core_param: two instances (single core; core 1 of 2) with a behavioural memory.
module tb_matmul_core_param;

  typedef struct {
    int dut;
    int n;
    int delay;
    int fill;     // 0 = reference 2x2 pattern, 1 = random, 2 = all 300
    bit poke;     // extra START pulse while busy
    bit exp_err;
  } job_t;

  logic clk = 1'b0;
  logic RESET;
  logic start [2];
  logic req [2], we [2], ack [2], busy [2], endi [2], err [2];
  logic [15:0] addr [2], wdata [2], rdata [2];

  logic [15:0] mem [2][256];
  bit          wflag [2][256];
  int          wr_cnt [2], unstable [2], wcnt [2];
  logic [15:0] cap_addr [2], cap_wd [2];
  logic        cap_we [2];
  int          ack_delay, stall_lo, stall_hi;
  int          total, bad;
  longint      am [6][6], bm [6][6];

  always #5 clk = ~clk;

  matmul_core_param #(.DATA_W(16), .ADDR_W(16), .CORE_ID(0), .NUM_CORES(1), .MAX_N(32)) u0 (
    .clk(clk), .RESET(RESET), .START(start[0]),
    .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_ack(ack[0]), .mem_rdata(rdata[0]),
    .busy(busy[0]), .end_i(endi[0]), .err(err[0])
  );

  matmul_core_param #(.DATA_W(16), .ADDR_W(16), .CORE_ID(1), .NUM_CORES(2), .MAX_N(32)) u1 (
    .clk(clk), .RESET(RESET), .START(start[1]),
    .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_ack(ack[1]), .mem_rdata(rdata[1]),
    .busy(busy[1]), .end_i(endi[1]), .err(err[1])
  );

  // Memory responder: acks after ack_delay wait cycles, never acks stalled addresses.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (RESET === 1'b1 || ack[d] === 1'b1) begin
        ack[d]  = 1'b0;
        wcnt[d] = 0;
      end
      if (RESET === 1'b0 && req[d] === 1'b1) begin
        if (wcnt[d] == 0) begin
          cap_addr[d] = addr[d];
          cap_we[d]   = we[d];
          cap_wd[d]   = wdata[d];
        end else if (addr[d] !== cap_addr[d] || we[d] !== cap_we[d] ||
                     (we[d] === 1'b1 && wdata[d] !== cap_wd[d])) begin
          unstable[d]++;
        end
        if (wcnt[d] >= ack_delay && !(int'(addr[d]) >= stall_lo && int'(addr[d]) <= stall_hi)) begin
          ack[d] = 1'b1;
          if (we[d] === 1'b1) begin
            mem[d][addr[d][7:0]]   = wdata[d];
            wflag[d][addr[d][7:0]] = 1'b1;
            wr_cnt[d]++;
          end else begin
            rdata[d] = mem[d][addr[d][7:0]];
          end
        end else begin
          wcnt[d]++;
        end
      end else begin
        wcnt[d] = 0;
      end
    end
  end

  function automatic logic [15:0] fmt(input longint v);
    logic [63:0] u;
`ifdef MATMUL_SAT_EN
    if (v > 64'sd32767) return 16'h7FFF;
    if (v < -64'sd32768) return 16'h8000;
`endif
    u = v;
    return u[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int d, input int n, input int kind);
    logic [15:0] av, bv;
    for (int x = 0; x < 256; x++) begin
      mem[d][x]   = 16'hDEAD;
      wflag[d][x] = 1'b0;
    end
    wr_cnt[d]   = 0;
    unstable[d] = 0;
    mem[d][0]   = 16'(n);
    if (n >= 1 && n <= 5) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          case (kind)
            0:       begin av = 16'(r * 2 + c + 1); bv = 16'(r * 2 + c + 5); end
            2:       begin av = 16'd300;            bv = 16'd300;            end
            default: begin av = 16'($urandom);      bv = 16'($urandom);      end
          endcase
          am[r][c] = longint'($signed(av));
          bm[r][c] = longint'($signed(bv));
          mem[d][1 + r * n + c]         = av;
          mem[d][1 + n * n + r * n + c] = bv;
        end
      end
    end
  endtask

  task automatic run_job(input job_t jb);
    int d, n, nc, rows, cyc, owned, ca;
    longint s;
    d = jb.dut;
    n = jb.n;
    nc = (d == 0) ? 1 : 2;
    ack_delay = jb.delay;
    fill(d, n, jb.fill);
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    while (endi[d] !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start[d] = (jb.poke && cyc == 10) ? 1'b1 : 1'b0;
    end
    start[d] = 1'b0;
    check("end_reached", endi[d], 1);
    rows = 0;
    if (n <= 32) for (int r = d; r < n; r += nc) rows++;
    if (jb.delay == 0) check("end_cycle", cyc, 2 + rows * n * (3 * n + 2) + 1);
    check("err", err[d], jb.exp_err);
    check("busy_done", busy[d], 0);
    owned = 0;
    if (n >= 1 && n <= 5) begin
      for (int r = 0; r < n; r++) begin
        if (r % nc == d) begin
          for (int c = 0; c < n; c++) begin
            s = 0;
            for (int x = 0; x < n; x++) s += am[r][x] * bm[x][c];
            ca = 1 + 2 * n * n + r * n + c;
            owned++;
            check("c_written", wflag[d][ca], 1);
            check("c_value", mem[d][ca], fmt(s));
          end
        end
      end
    end
    check("write_count", wr_cnt[d], owned);
    check("port_stable", unstable[d], 0);
  endtask

  initial begin
    job_t        jobs [6];
    job_t        jr;
    int          cnt;
    logic [15:0] sat_exp;

    total = 0; bad = 0;
    ack_delay = 0; stall_lo = 1; stall_hi = 0;
    start[0] = 1'b0; start[1] = 1'b0;
    wr_cnt[0] = 0; wr_cnt[1] = 0; unstable[0] = 0; unstable[1] = 0;
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req", req[d], 0);
      check("rst_we", we[d], 0);
      check("rst_addr", addr[d], 0);
      check("rst_wdata", wdata[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_end", endi[d], 0);
      check("rst_err", err[d], 0);
    end

    // Reference 2x2 job on a single core.
    run_job('{0, 2, 0, 0, 1'b0, 1'b0});
    check("c9", mem[0][9], 19);
    check("c10", mem[0][10], 22);
    check("c11", mem[0][11], 43);
    check("c12", mem[0][12], 50);

    // Core 1 of 2 writes only row 1.
    run_job('{1, 2, 0, 0, 1'b0, 1'b0});
    check("core1_no9", wflag[1][9], 0);
    check("core1_no10", wflag[1][10], 0);
    check("core1_c11", mem[1][11], 43);
    check("core1_c12", mem[1][12], 50);

    // 300*300 = 90000 overflows 16 bits.
    run_job('{0, 1, 0, 2, 1'b0, 1'b0});
`ifdef MATMUL_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h5F90;
`endif
    check("fmt_300sq", mem[0][3], sat_exp);

    // RESET while a B read waits, then a rerun with a START poke while busy.
    fill(0, 2, 0);
    stall_lo = 5; stall_hi = 8; ack_delay = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cnt = 0;
    while (!(req[0] === 1'b1 && addr[0] >= 16'd5 && addr[0] <= 16'd8) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("rdb_reached", cnt < 100, 1);
    repeat (2) @(negedge clk);
    check("rdb_waiting", req[0], 1);
    RESET = 1'b1;
    @(negedge clk);
    check("rst_mid_req", req[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_addr", addr[0], 0);
    RESET = 1'b0;
    stall_lo = 1; stall_hi = 0;
    check("rst_mid_nowrite", wr_cnt[0], 0);
    run_job('{0, 2, 0, 0, 1'b1, 1'b0});

    jobs[0] = '{0, 2, 3, 0, 1'b0, 1'b0};
    jobs[1] = '{0, 0, 0, 1, 1'b0, 1'b0};
    jobs[2] = '{0, 33, 0, 1, 1'b0, 1'b1};
    jobs[3] = '{1, 3, 0, 1, 1'b0, 1'b0};
    jobs[4] = '{0, 4, 2, 1, 1'b0, 1'b0};
    jobs[5] = '{1, 5, 1, 1, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) run_job(jobs[t]);

    for (int r = 0; r < 6; r++) begin
      jr.dut     = int'($urandom_range(0, 1));
      jr.n       = int'($urandom_range(1, 5));
      jr.delay   = int'($urandom_range(0, 2));
      jr.fill    = 1;
      jr.poke    = 1'b0;
      jr.exp_err = 1'b0;
      run_job(jr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
